// File: rtl/pixel_stream_tx.sv
// Raster-order frame-buffer reader driving a valid-qualified pixel stream.
// Optional row blanking: define PIXEL_STREAM_BLANK_GAP_EN.
module pixel_stream_tx #(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
`ifdef PIXEL_STREAM_BLANK_GAP_EN
        S_GAP,
`endif
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            drain_cnt;
    logic            ren_d1;
    logic            row_end;
    logic            last;

`ifdef PIXEL_STREAM_BLANK_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GW-1:0]   gap_cnt;
`endif

    assign row_end = (col == COL_LAST);
    assign last    = row_end && (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_READ;
            S_READ: begin
                if (last) nxt = S_DRAIN;
`ifdef PIXEL_STREAM_BLANK_GAP_EN
                else if (row_end) nxt = S_GAP;
`endif
            end
`ifdef PIXEL_STREAM_BLANK_GAP_EN
            S_GAP:   if (gap_cnt == '0) nxt = S_READ;
`endif
            S_DRAIN: if (drain_cnt) nxt = S_FIN;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ren = (state == S_READ);
        done    = (state == S_FIN);
        busy    = (state != S_IDLE) && (state != S_FIN);
    end

    // mem_addr always points at the next pixel to fetch; it parks at 0
    // after the final fetch so it never leaves the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mem_addr  <= '0;
            drain_cnt <= 1'b0;
`ifdef PIXEL_STREAM_BLANK_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        col      <= '0;
                        row      <= '0;
                        mem_addr <= '0;
                    end
                end
                S_READ: begin
                    if (last) begin
                        col       <= '0;
                        row       <= '0;
                        mem_addr  <= '0;
                        drain_cnt <= 1'b0;
                    end else if (row_end) begin
                        col      <= '0;
                        row      <= row + RW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
`ifdef PIXEL_STREAM_BLANK_GAP_EN
                        gap_cnt  <= GW'(GAP - 1);
`endif
                    end else begin
                        col      <= col + CW'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
`ifdef PIXEL_STREAM_BLANK_GAP_EN
                S_GAP:   gap_cnt <= gap_cnt - GW'(1);
`endif
                S_DRAIN: drain_cnt <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ren_d1    <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            ren_d1    <= mem_ren;
            pix_valid <= ren_d1;
            if (ren_d1) pix_data <= mem_rdata;
        end
    end

endmodule
